// File: rtl/uart_tx_responder.sv
// uart_tx_responder: memory-mapped 8N1 UART transmitter behind a valid/ready responder port.
// Optional build macro: UART_PARITY_EN adds a parity bit (DIV[16] selects 0 even / 1 odd).
// Ports:
//   clk, rst (async active-low)
//   memory_valid/instr/addr/wdata/wstrb : request, held stable until memory_ready
//   memory_rdata/memory_ready           : registered response, ready is a 1-cycle pulse
//   uart_tx                             : registered serial output, idle high
// Registers (addr[3:2]): 0 DATA (push), 1 STATUS, 2 DIV, 3 reserved.
module uart_tx_responder #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_RESET  = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memory_valid,
  input  logic        memory_instr,
  input  logic [31:0] memory_addr,
  input  logic [31:0] memory_wdata,
  input  logic [3:0]  memory_wstrb,
  output logic [31:0] memory_rdata,
  output logic        memory_ready,
  output logic        uart_tx
);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t           state_q, state_d;
  logic [15:0]      baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       data_q, data_d;
  logic             tx_d;
  logic             pop;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [15:0]      div_q;
`ifdef UART_PARITY_EN
  logic             par_odd;
`endif

  logic [1:0]  sel;
  logic        is_write, push_req, push, accept, fifo_full, fifo_empty;
  logic [31:0] rd_val;
  logic        unused;

  // Request decode; a DATA push into a full FIFO stalls until a slot frees
  assign sel        = memory_addr[3:2];
  assign is_write   = !memory_instr && (memory_wstrb != 4'd0);
  assign push_req   = is_write && (sel == REG_DATA) && memory_wstrb[0];
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign accept     = memory_valid && !memory_ready && !(push_req && fifo_full);
  assign push       = accept && push_req;
  assign unused     = ^{memory_addr[31:4], memory_addr[1:0], memory_wdata[31:16], memory_wstrb[3:2]};

  // Read mux, sampled on the accept cycle
  always_comb begin
    rd_val = '0;
    if (!memory_instr) begin
      case (sel)
        REG_STATUS: rd_val = {16'd0, 8'(count), 5'd0, fifo_full, fifo_empty, state_q != S_IDLE};
`ifdef UART_PARITY_EN
        REG_DIV:    rd_val = {15'd0, par_odd, div_q};
`else
        REG_DIV:    rd_val = {16'd0, div_q};
`endif
        default:    rd_val = '0;
      endcase
    end
  end

  // Bus response and DIV register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      memory_ready <= 1'b0;
      memory_rdata <= '0;
      div_q        <= 16'(DIV_RESET);
`ifdef UART_PARITY_EN
      par_odd      <= 1'b0;
`endif
    end else begin
      memory_ready <= accept;
      memory_rdata <= accept ? rd_val : '0;
      if (accept && is_write && (sel == REG_DIV)) begin
        if (memory_wstrb[0]) div_q[7:0]  <= memory_wdata[7:0];
        if (memory_wstrb[1]) div_q[15:8] <= memory_wdata[15:8];
`ifdef UART_PARITY_EN
        if (memory_wstrb[2]) par_odd     <= memory_wdata[16];
`endif
      end
    end
  end

  // FIFO storage (contents need no reset; pointers define validity)
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= memory_wdata[7:0];
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // TX state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      uart_tx <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      uart_tx <= tx_d;
    end
  end

  // TX next-state; uart_tx only changes at bit boundaries, baud reloads from DIV each boundary
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    data_d  = data_q;
    tx_d    = uart_tx;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          data_d  = fifo_mem[rd_ptr];
          baud_d  = div_q;
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (baud_q == '0) begin
          baud_d  = div_q;
          bit_d   = '0;
          state_d = S_DATA;
          tx_d    = data_q[0];
        end else baud_d = baud_q - 16'd1;
      end
      S_DATA: begin
        if (baud_q == '0) begin
          baud_d = div_q;
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = S_PARITY;
            tx_d    = (^data_q) ^ par_odd;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = data_q[bit_d];
          end
        end else baud_d = baud_q - 16'd1;
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (baud_q == '0) begin
          baud_d  = div_q;
          state_d = S_STOP;
          tx_d    = 1'b1;
        end else baud_d = baud_q - 16'd1;
      end
`endif
      S_STOP: begin
        if (baud_q == '0) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            data_d  = fifo_mem[rd_ptr];
            baud_d  = div_q;
            state_d = S_START;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else baud_d = baud_q - 16'd1;
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_tx_responder.sv
// Self-checking bench for uart_tx_responder: frame-level reference model plus literal checks.
module tb_uart_tx_responder;
  localparam int DEPTH = 16;
  localparam int DIVR  = 868;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        memory_valid = 1'b0;
  logic        memory_instr = 1'b0;
  logic [31:0] memory_addr  = '0;
  logic [31:0] memory_wdata = '0;
  logic [3:0]  memory_wstrb = '0;
  logic [31:0] memory_rdata;
  logic        memory_ready;
  logic        uart_tx;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_responder #(.FIFO_DEPTH(DEPTH), .DIV_RESET(DIVR)) dut (
    .clk(clk), .rst(rst),
    .memory_valid(memory_valid), .memory_instr(memory_instr),
    .memory_addr(memory_addr), .memory_wdata(memory_wdata), .memory_wstrb(memory_wstrb),
    .memory_rdata(memory_rdata), .memory_ready(memory_ready), .uart_tx(uart_tx)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: byte queue + current frame as a bit list ----------------
  byte unsigned mq[$];
  logic        m_ready = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        m_busy  = 1'b0;
  logic [10:0] m_bits  = '1;
  int          m_pos   = 0;
  int          m_left  = 0;
  logic [15:0] m_div   = 16'(DIVR);
  logic        m_par   = 1'b0;
  logic [1:0]  m_sel;
  logic        m_wr, m_push, m_acc;
  logic [31:0] m_rv;

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
    return f;
  endfunction

  task automatic model_start();
    m_bits = frame_of(8'(mq.pop_front()));
    m_pos  = 0;
    m_left = int'(m_div);
    m_busy = 1'b1;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_ready = 1'b0; m_rdata = '0; m_busy = 1'b0; m_pos = 0; m_left = 0;
      m_div = 16'(DIVR); m_par = 1'b0;
    end else begin
      m_sel  = memory_addr[3:2];
      m_wr   = !memory_instr && (memory_wstrb != 4'd0);
      m_push = m_wr && (m_sel == 2'd0) && memory_wstrb[0];
      m_acc  = memory_valid && !m_ready && !(m_push && mq.size() == DEPTH);
      m_rv   = '0;
      if (!memory_instr) begin
        if (m_sel == 2'd1)
          m_rv = {16'd0, 8'(mq.size()), 5'd0, mq.size() == DEPTH, mq.size() == 0, m_busy};
        else if (m_sel == 2'd2)
`ifdef UART_PARITY_EN
          m_rv = {15'd0, m_par, m_div};
`else
          m_rv = {16'd0, m_div};
`endif
      end
      // serial side: advance one clock within the current frame
      if (!m_busy) begin
        if (mq.size() > 0) model_start();
      end else if (m_left == 0) begin
        m_pos++;
        if (m_pos == NB) begin
          if (mq.size() > 0) model_start();
          else m_busy = 1'b0;
        end else begin
          m_left = int'(m_div);
`ifdef UART_PARITY_EN
          if (m_pos == 9) m_bits[9] = (^m_bits[8:1]) ^ m_par;
`endif
        end
      end else m_left--;
      // bus side effects
      if (m_acc && m_push) mq.push_back(memory_wdata[7:0]);
      if (m_acc && m_wr && m_sel == 2'd2) begin
        if (memory_wstrb[0]) m_div[7:0]  = memory_wdata[7:0];
        if (memory_wstrb[1]) m_div[15:8] = memory_wdata[15:8];
`ifdef UART_PARITY_EN
        if (memory_wstrb[2]) m_par = memory_wdata[16];
`endif
      end
      m_ready = m_acc;
      m_rdata = m_acc ? m_rv : '0;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (rst) begin
      check("ready", 32'(memory_ready), 32'(m_ready));
      if (m_ready) check("rdata", memory_rdata, m_rdata);
      check("uart_tx", 32'(uart_tx), 32'(m_busy ? m_bits[m_pos] : 1'b1));
    end
  end

  // ---------------- stimulus helpers (all start and end at posedge+1) ----------------
  task automatic xfer(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, output logic [31:0] rd, output int lat);
    bit done;
    memory_valid = 1'b1; memory_instr = instr; memory_addr = addr;
    memory_wdata = wdata; memory_wstrb = wstrb;
    lat = 0; rd = '0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      lat++;
      if (memory_ready) done = 1'b1;
      else if (lat > 5000) begin
        checks++; failures++;
        $display("FAIL xfer_timeout addr=0x%08h waited=%0d", addr, lat);
        done = 1'b1;
      end
    end
    rd = memory_rdata;
    @(posedge clk); #1;
    memory_valid = 1'b0; memory_instr = 1'b0; memory_wstrb = '0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] rd; int lat;
    xfer(1'b0, addr, data, 4'hF, rd, lat);
  endtask

  task automatic rdr(input logic [31:0] addr, output logic [31:0] rd);
    int lat;
    xfer(1'b0, addr, 32'h0, 4'h0, rd, lat);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b0;
    #1;
    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_ready", 32'(memory_ready), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
  endtask

  // Wait (bounded) for a start bit, then sample n cycles and compare with a bit pattern
  task automatic capture(input string name, input int n, input int hold, input logic [10:0] pat, input int nb);
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (uart_tx && w < 40);
    check({name, "_start_seen"}, 32'(uart_tx), 32'd0);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      check(name, 32'(uart_tx), 32'(pat[(i / hold) % nb]));
    end
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    logic [10:0] seq_a5, seq_zero;
    logic [1:0]  rs;
    logic [3:0]  rstrb;
    logic [31:0] rdat;

`ifdef UART_PARITY_EN
    seq_a5   = 11'b101_0100_1010;
    seq_zero = 11'b100_0000_0000;
`else
    seq_a5   = 11'b011_0100_1010;
    seq_zero = 11'b010_0000_0000;
`endif

    idle(3);
    rst = 1'b1;

    // Reset mid-frame
    wr(32'h8, 32'd3);
    wr(32'h0, 32'h5A);
    idle(12);
    pulse_reset();
    rdr(32'h4, rd); check("status_after_reset", rd, 32'h0000_0002);
    rdr(32'h8, rd); check("div_after_reset", rd, 32'd868);

    // DIV=3, byte 0xA5: each bit held 4 cycles
    wr(32'h8, 32'd3);
    wr(32'h0, 32'hA5);
    capture("frame_a5", 4 * NB, 4, seq_a5, NB);
    idle(3);
    rdr(32'h4, rd); check("status_idle_after_frame", rd, 32'h0000_0002);

    // DIV=0, three back-to-back frames with no idle gap
    wr(32'h8, 32'd0);
    fork
      begin
        wr(32'h0, 32'h00);
        wr(32'h0, 32'h00);
        wr(32'h0, 32'h00);
      end
      capture("b2b_frames", 3 * NB, 1, seq_zero, NB);
    join
    idle(10);

    // FIFO fill and stall
    pulse_reset();
    wr(32'h8, 32'd100);
    for (int k = 0; k < DEPTH + 2; k++) begin
      xfer(1'b0, 32'h0, 32'(k), 4'h1, rd, lat);
      if (k < DEPTH + 1) check("fill_latency", 32'(lat), 32'd2);
      else               check("stall_released_late", 32'(lat > 100), 32'd1);
    end
    rdr(32'h4, rd); check("status_full", rd, 32'h0000_1005);

    // Fetch / reserved / DATA read: 1-cycle ready, zero data, no FIFO change
    pulse_reset();
    xfer(1'b1, 32'h0, 32'h55, 4'hF, rd, lat);
    check("fetch_lat", 32'(lat), 32'd2); check("fetch_rdata", rd, 32'd0);
    xfer(1'b0, 32'hC, 32'h0, 4'h0, rd, lat);
    check("rsvd_lat", 32'(lat), 32'd2); check("rsvd_rdata", rd, 32'd0);
    xfer(1'b0, 32'h0, 32'h0, 4'h0, rd, lat);
    check("data_read_lat", 32'(lat), 32'd2); check("data_read_rdata", rd, 32'd0);
    rdr(32'h4, rd); check("status_unchanged", rd, 32'h0000_0002);

    // Parity select in DIV[16]
    wr(32'h8, 32'h0001_0003);
    rdr(32'h8, rd);
`ifdef UART_PARITY_EN
    check("div_parity_read", rd, 32'h0001_0003);
`else
    check("div_parity_read", rd, 32'h0000_0003);
`endif
    wr(32'h0, 32'h01);
    idle(60);

    // Randomized traffic against the model
    pulse_reset();
    wr(32'h8, 32'd1);
    for (int n = 0; n < 400; n++) begin
      rs    = 2'($urandom_range(0, 3));
      rstrb = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      rdat  = $urandom;
      if (rs == 2'd2) rdat[15:2] = '0;
      xfer(($urandom_range(0, 15) == 0), {28'($urandom), rs, 2'($urandom)}, rdat, rstrb, rd, lat);
      idle(int'($urandom_range(0, 3)));
      if (n == 200) pulse_reset();
    end
    idle(DEPTH * NB * 5 + 50);
    rdr(32'h4, rd); check("status_drained", rd, 32'h0000_0002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
